// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: valid/ready request, fixed multi-cycle latency, one-cycle response pulse.
// Optional address-range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_responder #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [7:0]        req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_write;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_oor;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                w_accept;
   logic                w_fire;
   logic                w_oor;

`ifdef DMEM_RANGE_CHECK_EN
   assign w_oor = ({1'b0, req_addr} >= 9'(DEPTH));
`else
   // Upper address bits only matter when range checking is built in.
   logic w_unused_addr;
   assign w_unused_addr = ^req_addr;
   assign w_oor         = 1'b0;
`endif

   assign w_accept   = req_valid && req_ready;
   assign w_fire     = (r_state == WAIT) && (r_cnt == '0);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = WAIT;
         end
         WAIT: begin
            if (r_cnt == '0) w_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem   <= '{default: '0};
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_oor   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_idx   <= req_addr[ADDR_W-1:0];
         r_wdata <= req_wdata;
         r_oor   <= w_oor;
         r_cnt   <= 4'(LATENCY - 1);
      end else if (w_fire) begin
         // Out-of-range accesses leave storage untouched and report zero data.
         if (r_oor) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end else if (r_write) begin
            r_mem[r_idx] <= r_wdata;
            r_rdata      <= r_wdata;
            r_err        <= 1'b0;
         end else begin
            r_rdata <= r_mem[r_idx];
            r_err   <= 1'b0;
         end
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

endmodule
